// File: rtl/verifla_rle_capture_ctrl.sv
// Run-length capture controller for the logic analyser core.
// Probe samples are folded into {count,data} lines. A circular pre-trigger
// window occupies the lowest addresses, the post-trigger region fills upward
// to DEPTH-2, and the top line holds a bookmark: the address of the last
// pre-trigger write, so the dump logic can unroll the circular window.
module verifla_rle_capture_ctrl #(
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 8,
    parameter int ADDR_W   = 6,
    parameter int PRE_TRIG = 4
) (
    input  logic                    clk_of_verifla,
    input  logic                    rst,
    input  logic                    arm,
    input  logic [DATA_W-1:0]       data_in,
    input  logic [DATA_W-1:0]       trig_value,
    input  logic [DATA_W-1:0]       trig_mask,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [CNT_W+DATA_W-1:0] mem_wdata,
    output logic                    la_trigger_matched,
    output logic                    capture_done
);

    localparam int                LINE_W     = CNT_W + DATA_W;
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [ADDR_W-1:0] PRE_LAST   = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] POST_FIRST = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] POST_LAST  = ADDR_W'((2 ** ADDR_W) - 2);
    localparam logic [ADDR_W-1:0] BMARK_ADDR = '1;

    typedef enum logic [2:0] {IDLE, PRE, POST, BMARK, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    run_cnt;
    logic [DATA_W-1:0]   run_data;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   last_pre;

    logic                trig_hit;
    logic                run_extend;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [LINE_W-1:0]   wr_line;
    logic                load_run;
    logic                inc_run;
    logic                set_trig;
    logic                set_done;
    logic [ADDR_W-1:0]   ptr_nxt;
    logic [ADDR_W-1:0]   last_pre_nxt;

    // A sample extends the current run only while the data repeats and the
    // counter still has headroom; a saturated run forces a line out.
    assign trig_hit   = ((data_in ^ trig_value) & trig_mask) == '0;
    assign run_extend = (data_in == run_data) && (run_cnt != CNT_MAX);

    // State register.
    always_ff @(posedge clk_of_verifla) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dropping arm aborts from any state.
    always_comb begin
        state_nxt = state;
        if (!arm) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = PRE;
                PRE:     if (trig_hit) state_nxt = POST;
                POST:    if (!run_extend && (wr_ptr == POST_LAST)) state_nxt = BMARK;
                BMARK:   state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Per-cycle decisions: which line to write, how the run and pointers move.
    always_comb begin
        wr_en        = 1'b0;
        wr_addr      = wr_ptr;
        wr_line      = {run_cnt, run_data};
        load_run     = 1'b0;
        inc_run      = 1'b0;
        set_trig     = 1'b0;
        set_done     = 1'b0;
        ptr_nxt      = wr_ptr;
        last_pre_nxt = last_pre;
        if (arm) begin
            case (state)
                IDLE: begin
                    load_run     = 1'b1;
                    ptr_nxt      = '0;
                    last_pre_nxt = '0;
                end
                PRE: begin
                    // The triggering sample is never merged into the open run.
                    if (trig_hit || !run_extend) begin
                        wr_en        = 1'b1;
                        load_run     = 1'b1;
                        last_pre_nxt = wr_ptr;
                        if (trig_hit) begin
                            ptr_nxt  = POST_FIRST;
                            set_trig = 1'b1;
                        end else begin
                            ptr_nxt  = (wr_ptr == PRE_LAST) ? '0 : wr_ptr + ADDR_W'(1);
                        end
                    end else begin
                        inc_run = 1'b1;
                    end
                end
                POST: begin
                    if (run_extend) begin
                        inc_run = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        load_run = 1'b1;
                        ptr_nxt  = wr_ptr + ADDR_W'(1);
                    end
                end
                BMARK: begin
                    wr_en    = 1'b1;
                    wr_addr  = BMARK_ADDR;
                    wr_line  = LINE_W'(last_pre);
                    set_done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Registered RAM port, flags, run register and pointers.
    always_ff @(posedge clk_of_verifla) begin
        if (rst) begin
            mem_we             <= 1'b0;
            mem_addr           <= '0;
            mem_wdata          <= '0;
            la_trigger_matched <= 1'b0;
            capture_done       <= 1'b0;
            run_cnt            <= '0;
            run_data           <= '0;
            wr_ptr             <= '0;
            last_pre           <= '0;
        end else begin
            mem_we <= wr_en;
            if (wr_en) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_line;
            end
            if (!arm) begin
                la_trigger_matched <= 1'b0;
                capture_done       <= 1'b0;
            end else begin
                if (set_trig) la_trigger_matched <= 1'b1;
                if (set_done) capture_done       <= 1'b1;
            end
            if (load_run) begin
                run_cnt  <= CNT_W'(1);
                run_data <= data_in;
            end else if (inc_run) begin
                run_cnt  <= run_cnt + CNT_W'(1);
            end
            wr_ptr   <= ptr_nxt;
            last_pre <= last_pre_nxt;
        end
    end

endmodule

// File: tb/tb_verifla_rle_capture_ctrl.sv
// Bench for the run-length capture controller: a hand-written vector table,
// a reference model feeding a write scoreboard, and a reduced-size instance.
module tb_verifla_rle_capture_ctrl;

    localparam int M_DEPTH = 64;
    localparam int M_PRE   = 4;
    localparam int M_MAX   = 255;
    localparam int M_IDLE  = 0;
    localparam int M_PREST = 1;
    localparam int M_POST  = 2;
    localparam int M_BMARK = 3;
    localparam int M_DONE  = 4;

    logic        clk;
    logic        rst;
    logic        arm;
    logic [15:0] data_in;
    logic [15:0] tv;
    logic [15:0] tm;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [23:0] mem_wdata;
    logic        la_trigger_matched;
    logic        capture_done;

    logic        arm2;
    logic [7:0]  data2;
    logic [7:0]  tv2;
    logic [7:0]  tm2;
    logic        mem_we2;
    logic [3:0]  mem_addr2;
    logic [15:0] mem_wdata2;
    logic        trig2;
    logic        done2;

    verifla_rle_capture_ctrl dut (
        .clk_of_verifla     (clk),
        .rst                (rst),
        .arm                (arm),
        .data_in            (data_in),
        .trig_value         (tv),
        .trig_mask          (tm),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .la_trigger_matched (la_trigger_matched),
        .capture_done       (capture_done)
    );

    verifla_rle_capture_ctrl #(.DATA_W(8), .CNT_W(8), .ADDR_W(4), .PRE_TRIG(2)) dut_small (
        .clk_of_verifla     (clk),
        .rst                (rst),
        .arm                (arm2),
        .data_in            (data2),
        .trig_value         (tv2),
        .trig_mask          (tm2),
        .mem_we             (mem_we2),
        .mem_addr           (mem_addr2),
        .mem_wdata          (mem_wdata2),
        .la_trigger_matched (trig2),
        .capture_done       (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        arm;
        logic [15:0] data;
        logic        we;
        logic [5:0]  addr;
        logic [23:0] wdata;
        logic        trig;
        logic        done;
    } vec_t;

    typedef struct {
        logic [5:0]  addr;
        logic [23:0] wdata;
    } sb_t;

    vec_t vecs [16];
    sb_t  sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int          m_st, m_cnt, m_wp, m_lp;
    logic [15:0] m_dat;
    logic        m_trig, m_done;

    task automatic push_wr(input int addr, input int cnt, input logic [15:0] dat);
        sb_t e;
        e.addr  = 6'(addr);
        e.wdata = {8'(cnt), dat};
        sb.push_back(e);
    endtask

    // Reference behaviour of one clock edge with the given inputs.
    task automatic model_step(input logic a, input logic [15:0] d, input logic r);
        logic hit, ext;
        if (r) begin
            m_st = M_IDLE; m_cnt = 0; m_dat = 16'h0; m_wp = 0; m_lp = 0;
            m_trig = 1'b0; m_done = 1'b0;
            return;
        end
        if (!a) begin
            m_st = M_IDLE; m_trig = 1'b0; m_done = 1'b0;
            return;
        end
        hit = ((d ^ tv) & tm) == 16'h0;
        ext = (d == m_dat) && (m_cnt < M_MAX);
        case (m_st)
            M_IDLE: begin
                m_cnt = 1; m_dat = d; m_wp = 0; m_lp = 0; m_st = M_PREST;
            end
            M_PREST: begin
                if (hit) begin
                    push_wr(m_wp, m_cnt, m_dat);
                    m_lp = m_wp; m_wp = M_PRE; m_cnt = 1; m_dat = d;
                    m_trig = 1'b1; m_st = M_POST;
                end else if (ext) begin
                    m_cnt++;
                end else begin
                    push_wr(m_wp, m_cnt, m_dat);
                    m_lp = m_wp; m_wp = (m_wp + 1) % M_PRE; m_cnt = 1; m_dat = d;
                end
            end
            M_POST: begin
                if (ext) begin
                    m_cnt++;
                end else begin
                    push_wr(m_wp, m_cnt, m_dat);
                    if (m_wp == M_DEPTH - 2) m_st = M_BMARK;
                    m_wp++; m_cnt = 1; m_dat = d;
                end
            end
            M_BMARK: begin
                push_wr(M_DEPTH - 1, 0, 16'(m_lp));
                m_done = 1'b1; m_st = M_DONE;
            end
            default: begin
            end
        endcase
    endtask

    task automatic check_sb(input logic r);
        sb_t e;
        n_tests++;
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_write: got addr=%0d data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                e = sb.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.wdata) begin
                    n_fail++;
                    $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             mem_addr, mem_wdata, e.addr, e.wdata);
                end
            end
        end else if (sb.size() != 0) begin
            e = sb.pop_front();
            n_fail++;
            $display("FAIL sb_missing_write: got we=%b, required addr=%0d data=%h", mem_we, e.addr, e.wdata);
        end
        n_tests++;
        if (la_trigger_matched !== m_trig || capture_done !== m_done) begin
            n_fail++;
            $display("FAIL sb_flags: got trig=%b done=%b, required trig=%b done=%b",
                     la_trigger_matched, capture_done, m_trig, m_done);
        end
        if (r) begin
            n_tests++;
            if (mem_we !== 1'b0 || mem_addr !== 6'd0 || mem_wdata !== 24'd0 ||
                la_trigger_matched !== 1'b0 || capture_done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got we=%b addr=%0d data=%h trig=%b done=%b, required all 0",
                         mem_we, mem_addr, mem_wdata, la_trigger_matched, capture_done);
            end
        end
    endtask

    task automatic drive(input logic a, input logic [15:0] d, input logic r);
        rst = r; arm = a; data_in = d;
        model_step(a, d, r);
        @(posedge clk);
        #1;
        check_sb(r);
    endtask

    initial begin
        logic [15:0] mem2 [16];
        int nwr2;
        int guard;

        rst = 1'b1; arm = 1'b0; data_in = 16'h0; tv = 16'h0005; tm = 16'hFFFF;
        arm2 = 1'b0; data2 = 8'h0; tv2 = 8'h04; tm2 = 8'hFF;

        // Counter data with trigger on 5, then an abort and re-arm.
        vecs[0]  = '{1'b1, 16'h0000, 1'b0, 6'd0, 24'h000000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 16'h0001, 1'b1, 6'd0, 24'h010000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 16'h0002, 1'b1, 6'd1, 24'h010001, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 16'h0003, 1'b1, 6'd2, 24'h010002, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 16'h0004, 1'b1, 6'd3, 24'h010003, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 16'h0005, 1'b1, 6'd0, 24'h010004, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 16'h0006, 1'b1, 6'd4, 24'h010005, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 16'h0006, 1'b0, 6'd0, 24'h000000, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 16'h0006, 1'b0, 6'd0, 24'h000000, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 16'h0007, 1'b1, 6'd5, 24'h030006, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 16'h0005, 1'b1, 6'd6, 24'h010007, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 16'h0005, 1'b0, 6'd0, 24'h000000, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 6'd0, 24'h000000, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 16'h0009, 1'b0, 6'd0, 24'h000000, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 16'h0009, 1'b0, 6'd0, 24'h000000, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 16'h0005, 1'b1, 6'd0, 24'h020009, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        model_step(1'b0, 16'h0, 1'b1);
        check_sb(1'b1);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            arm = vecs[i].arm; data_in = vecs[i].data;
            @(posedge clk);
            #1;
            n_tests++;
            if (mem_we !== vecs[i].we || la_trigger_matched !== vecs[i].trig ||
                capture_done !== vecs[i].done ||
                (vecs[i].we && (mem_addr !== vecs[i].addr || mem_wdata !== vecs[i].wdata))) begin
                n_fail++;
                $display("FAIL vec%0d: got we=%b addr=%0d data=%h trig=%b done=%b, required we=%b addr=%0d data=%h trig=%b done=%b",
                         i, mem_we, mem_addr, mem_wdata, la_trigger_matched, capture_done,
                         vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].trig, vecs[i].done);
            end
        end

        // Full capture of counter data: pre window wraps, post fills, bookmark.
        drive(1'b0, 16'h0, 1'b1);
        drive(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 80; i++) drive(1'b1, 16'(i), 1'b0);
        n_tests++;
        if (capture_done !== 1'b1) begin
            n_fail++;
            $display("FAIL counter_done: got %b, required 1", capture_done);
        end

        // Long constant runs: saturation in the pre and post regions.
        drive(1'b0, 16'h0, 1'b0);
        tv = 16'h0055;
        for (int i = 0; i < 300; i++) drive(1'b1, 16'h00AA, 1'b0);
        drive(1'b1, 16'h0055, 1'b0);
        for (int i = 0; i < 600; i++) drive(1'b1, 16'h00AA, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 16'h00BB, 1'b0);
        drive(1'b0, 16'h0, 1'b0);

        // Mask 0: trigger on the first pre cycle, random short runs.
        tm = 16'h0000;
        drive(1'b1, 16'h1234, 1'b0);
        for (int i = 0; i < 200; i++) drive(1'b1, 16'($urandom_range(0, 3)), 1'b0);
        n_tests++;
        if (capture_done !== 1'b1) begin
            n_fail++;
            $display("FAIL mask0_done: got %b, required 1", capture_done);
        end

        // Abort mid-post, then re-arm from address 0.
        drive(1'b0, 16'h0, 1'b0);
        tv = 16'h0030; tm = 16'h00F0;
        for (int i = 0; i < 12; i++) drive(1'b1, 16'($urandom_range(0, 2)), 1'b0);
        drive(1'b1, 16'h0031, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 16'($urandom_range(0, 2)), 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 16'(i), 1'b0);
        drive(1'b0, 16'h0, 1'b0);

        // Reset during the pre window.
        for (int i = 0; i < 6; i++) drive(1'b1, 16'(i), 1'b0);
        drive(1'b1, 16'h0007, 1'b1);
        drive(1'b0, 16'h0, 1'b0);

        // Reset in the bookmark cycle: the bookmark must never appear.
        tm = 16'h0000;
        guard = 0;
        drive(1'b1, 16'h0, 1'b0);
        while (m_st != M_BMARK && guard < 400) begin
            drive(1'b1, 16'($urandom_range(0, 3)), 1'b0);
            guard++;
        end
        n_tests++;
        if (m_st != M_BMARK) begin
            n_fail++;
            $display("FAIL bmark_reach: got %0d cycles without bookmark state, required < 400", guard);
        end
        drive(1'b1, 16'h0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 16'h0, 1'b0);
        drive(1'b0, 16'h0, 1'b0);

        // Reduced instance: 16 lines, 2 pre lines, trigger on 4.
        arm = 1'b0;
        nwr2 = 0;
        for (int k = 0; k < 16; k++) mem2[k] = 16'hDEAD;
        for (int i = 0; i < 40; i++) begin
            arm2 = 1'b1; data2 = 8'(i);
            @(posedge clk);
            #1;
            if (mem_we2 === 1'b1) begin
                mem2[mem_addr2] = mem_wdata2;
                nwr2++;
            end
        end
        n_tests++;
        if (mem2[0] !== 16'h0102 || mem2[1] !== 16'h0103) begin
            n_fail++;
            $display("FAIL small_pre: got %h %h, required 0102 0103", mem2[0], mem2[1]);
        end
        for (int k = 2; k < 15; k++) begin
            n_tests++;
            if (mem2[k] !== {8'h01, 8'(k + 2)}) begin
                n_fail++;
                $display("FAIL small_post%0d: got %h, required %h", k, mem2[k], {8'h01, 8'(k + 2)});
            end
        end
        n_tests++;
        if (mem2[15] !== 16'h0001) begin
            n_fail++;
            $display("FAIL small_bmark: got %h, required 0001", mem2[15]);
        end
        n_tests++;
        if (nwr2 != 18 || done2 !== 1'b1 || trig2 !== 1'b1) begin
            n_fail++;
            $display("FAIL small_status: got writes=%0d done=%b trig=%b, required 18 1 1", nwr2, done2, trig2);
        end

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
